// File: rtl/result_sink_if.sv
// Result stream handshake: upstream push side and downstream pop side of result_sink.
interface result_sink_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/result_sink.sv
// Result sink: buffers upstream result words in a small FIFO, counts matches/misses
// against MATCH_VAL and halts intake once MISS_LIMIT misses have been accepted.
module result_sink #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] MATCH_VAL  = 32'd25,
  parameter int unsigned MISS_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  result_sink_if.slave             bus,
  output logic [15:0]              match_count,
  output logic [15:0]              miss_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               state,
  output logic                     done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     match_q, match_d;
  logic [15:0]     miss_q, miss_d;
  logic [31:0]     mem_q [DEPTH];

  logic in_rdy;
  logic out_vld;
  logic push;
  logic pop;
  logic is_match;
  logic hit_limit;

  // Intake readiness is a function of registered state only, never of out_ready.
  assign in_rdy   = (state_q == RUN) && (level_q != LW'(DEPTH));
  assign out_vld  = (level_q != '0);
  assign push     = bus.in_valid && in_rdy;
  assign pop      = out_vld && bus.out_ready;
  assign is_match = (bus.in_data == MATCH_VAL);

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_vld ? mem_q[head_q] : '0;

  assign match_count = match_q;
  assign miss_count  = miss_q;
  assign level       = level_q;
  assign state       = state_q;
  assign done        = (state_q == HALT) && (level_q == '0);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    match_d   = match_q;
    miss_d    = miss_q;
    hit_limit = 1'b0;
    if (push) begin
      tail_d = tail_q + 1'b1;
      if (is_match) begin
        if (match_q != '1) match_d = match_q + 16'd1;
      end else if (miss_q != '1) begin
        miss_d    = miss_q + 16'd1;
        hit_limit = (miss_d == 16'(MISS_LIMIT));
      end
    end
    if (pop) head_d = head_q + 1'b1;
    level_d = level_q + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};

    // Reaching the miss limit outranks a simultaneous enable drop.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN: begin
        if (hit_limit)    state_d = HALT;
        else if (!enable) state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      match_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      match_q <= match_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= bus.in_data;
  end

endmodule
